// File: rtl/violation_reset_sequencer_if.sv
// Monitor-to-core reset-request bundle: level requests, pc and cause clear in; pulse, status out.
interface violation_reset_sequencer_if #(
  parameter int N_REQ = 3,
  parameter int CNT_W = 8
);
  logic [N_REQ-1:0] viol_req;
  logic [15:0]      pc;
  logic             cause_clr;
  logic             sys_rst;
  logic             busy;
  logic [N_REQ-1:0] cause;
  logic [CNT_W-1:0] viol_count;

  modport master (
    output viol_req, pc, cause_clr,
    input  sys_rst, busy, cause, viol_count
  );

  modport slave (
    input  viol_req, pc, cause_clr,
    output sys_rst, busy, cause, viol_count
  );
endinterface

// File: rtl/violation_reset_sequencer.sv
// Turns any monitor reset request into a fixed-length registered core reset pulse,
// records the cause, and re-arms only once the core fetches from the reset handler.
module violation_reset_sequencer #(
  parameter int          N_REQ         = 3,
  parameter int          RST_CYCLES    = 16,
  parameter int          CNT_W         = 8,
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter logic [15:0] SMEM_BASE     = 16'hE000,
  parameter logic [15:0] SMEM_SIZE     = 16'h1000
) (
  input  logic                         clk,
  input  logic                         rst,
  violation_reset_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {ARMED, ASSERT, WAIT_HANDLER} state_t;

  localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(RST_CYCLES - 1);
  localparam logic [16:0]      SROM_LO = {1'b0, SMEM_BASE};
  localparam logic [16:0]      SROM_HI = {1'b0, SMEM_BASE} + {1'b0, SMEM_SIZE} - 17'd2;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             req_any, pc_in_srom, clr_ok, bump;
  logic             sys_rst_q, busy_q;
  logic [N_REQ-1:0] cause_q;
  logic [CNT_W-1:0] viol_count_q;

  assign req_any    = |bus.viol_req;
  assign pc_in_srom = ({1'b0, bus.pc} >= SROM_LO) && ({1'b0, bus.pc} <= SROM_HI);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bump      = 1'b0;
    clr_ok    = 1'b0;
    case (state)
      ARMED: begin
        if (req_any) begin
          state_nxt = ASSERT;
          cnt_nxt   = RELOAD;
          bump      = 1'b1;
        end else if (bus.cause_clr && pc_in_srom) begin
          clr_ok = 1'b1;
        end
      end
      ASSERT: begin
        // A request while asserting stretches the pulse but is the same reset event
        if (req_any)           cnt_nxt   = RELOAD;
        else if (cnt == '0)    state_nxt = WAIT_HANDLER;
        else                   cnt_nxt   = cnt - CNT_W'(1);
      end
      WAIT_HANDLER: begin
        if (req_any) begin
          state_nxt = ASSERT;
          cnt_nxt   = RELOAD;
          bump      = 1'b1;
        end else if (bus.pc == RESET_HANDLER) begin
          state_nxt = ARMED;
        end
      end
      default: state_nxt = ARMED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ARMED;
      cnt          <= '0;
      sys_rst_q    <= 1'b0;
      busy_q       <= 1'b0;
      cause_q      <= '0;
      viol_count_q <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sys_rst_q <= (state_nxt == ASSERT);
      busy_q    <= (state_nxt != ARMED);
      cause_q   <= clr_ok ? '0 : (cause_q | bus.viol_req);
      if (clr_ok)
        viol_count_q <= '0;
      else if (bump && (viol_count_q != '1))
        viol_count_q <= viol_count_q + CNT_W'(1);
    end
  end

  assign bus.sys_rst    = sys_rst_q;
  assign bus.busy       = busy_q;
  assign bus.cause      = cause_q;
  assign bus.viol_count = viol_count_q;

endmodule
